mc_control_unit: RTL and testbench
==================================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter OPC_W, default 5, meaning opcode field width (inst[6:2]).
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning max memory-wait cycles before fault; 0 disables.
REQ-003 SHALL have parameter CNT_W, default 32, meaning retired-instruction counter width.
REQ-004 SHALL have one clock and a synchronous active-low reset, with ports as below.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active low.
- opcode  in  OPC_W  instruction opcode; valid in DECODE only.
- imem_ready  in  1  instruction memory has data.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC update.
- pc_write_cond  out  1  PC update if branch taken.
- mem_read / mem_write  out  1 each  data memory strobes.
- mem_to_reg  out  1  writeback source is memory.
- alu_src  out  1  ALU B operand is the immediate.
- alu_op  out  2  00 add, 01 compare, 10 R-funct, 11 I-funct.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky illegal-opcode flag.
- timeout  out  1  sticky memory-timeout flag.
- instret  out  CNT_W  retired-instruction count.

Function
REQ-005 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB, TRAP, and all outputs SHALL be Moore, decoded from the state and the latched opcode op_q.
REQ-006 FETCH: imem_req=1; on imem_ready, ir_write=1 and pc_write=1 in that same cycle, then -> DECODE; otherwise stay.
REQ-007 DECODE: op_q<=opcode; a legal opcode -> EXEC; any other opcode -> TRAP, illegal<=1.
REQ-008 Legal opcodes: R=01100, I=00100, LOAD=00000, STORE=01000, BRANCH=11000, JAL=11011, JALR=11001, LUI=01101, AUIPC=00101.
REQ-009 EXEC outputs, alu_op/alu_src: R 10/0; I 11/1; LOAD and STORE 00/1; BRANCH 01/0 with pc_write_cond=1; JAL and JALR 00/1 with pc_write=1; LUI and AUIPC 00/1.
REQ-010 EXEC next state: LOAD and STORE -> MEM; BRANCH -> FETCH (retires); all other legal opcodes -> WB.
REQ-011 MEM: mem_read=1 for LOAD and mem_write=1 for STORE, held until dmem_ready; on ready, LOAD -> WB and STORE -> FETCH (retires).
REQ-012 WB: reg_write=1 for one cycle, with mem_to_reg=1 only for LOAD; then -> FETCH (retires).
REQ-013 instret SHALL increment by 1 on each retiring transition and wrap modulo 2^CNT_W.
REQ-014 The wait counter SHALL count consecutive not-ready cycles in FETCH and MEM, and clear on ready or on a state change.
REQ-015 When TIMEOUT>0 and the wait count reaches TIMEOUT, the block SHALL go -> TRAP with timeout<=1; the ready input in that cycle is ignored.
REQ-016 TRAP: all strobes 0; the block stays in TRAP until reset; illegal and timeout are sticky.
REQ-017 All strobes not listed for a state SHALL be 0; no two of mem_read, mem_write and reg_write SHALL be 1 in the same cycle.

Reset
REQ-018 When rst_n=0 at a clock edge, the next state SHALL be state=FETCH, op_q=0, instret=0, wait count=0, illegal=0, timeout=0.
REQ-019 Reset SHALL take priority mid-operation: a pending MEM access is abandoned, and no retire or write occurs in the reset cycle.

Structure
REQ-020 Opcode constants, the state enum and the alu_op encodings SHALL live in the shared defines package.
REQ-021 The opcode-to-control decode SHALL be a sub-module mc_decode (combinational, op_q -> EXEC control bits and a legal flag); the FSM, counters and flags SHALL stay in mc_control_unit.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- R-type with imem_ready=1 -> FETCH, DECODE, EXEC, WB; reg_write=1 in cycle 4; instret=1 after 4 cycles.
- LOAD with dmem_ready delayed 3 cycles -> mem_read held for 4 cycles; WB has mem_to_reg=1; total 8 cycles.
- STORE then BRANCH -> mem_write pulse, no reg_write; BRANCH has pc_write_cond=1 in EXEC; instret=2.
- Opcode 11111 -> TRAP after DECODE; illegal=1 held; imem_req=0 thereafter.
- dmem_ready stuck 0 with TIMEOUT=16 -> TRAP after 16 MEM cycles; timeout=1; with TIMEOUT=0 it waits indefinitely.
- rst_n=0 during MEM -> next cycle state=FETCH, mem_read=0, instret=0, flags cleared.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared state, opcode and ALU-op encodings for the multi-cycle control unit.
package mc_control_unit_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StFetch  = 3'd0;
   localparam state_t StDecode = 3'd1;
   localparam state_t StExec   = 3'd2;
   localparam state_t StMem    = 3'd3;
   localparam state_t StWb     = 3'd4;
   localparam state_t StTrap   = 3'd5;

   localparam logic [4:0] OpR      = 5'b01100;
   localparam logic [4:0] OpI      = 5'b00100;
   localparam logic [4:0] OpLoad   = 5'b00000;
   localparam logic [4:0] OpStore  = 5'b01000;
   localparam logic [4:0] OpBranch = 5'b11000;
   localparam logic [4:0] OpJal    = 5'b11011;
   localparam logic [4:0] OpJalr   = 5'b11001;
   localparam logic [4:0] OpLui    = 5'b01101;
   localparam logic [4:0] OpAuipc  = 5'b00101;

   localparam logic [1:0] AluAdd    = 2'b00;
   localparam logic [1:0] AluCmp    = 2'b01;
   localparam logic [1:0] AluRFunct = 2'b10;
   localparam logic [1:0] AluIFunct = 2'b11;

   typedef struct packed {
      logic       legal;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       pc_write;
      logic       pc_write_cond;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
   } exec_ctrl_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit bus: opcode and memory handshakes in, datapath strobes and status out.
interface mc_control_unit_if #(
   parameter int unsigned OPC_W = 5,
   parameter int unsigned CNT_W = 32
);
   logic [OPC_W-1:0] opcode;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             ir_write;
   logic             pc_write;
   logic             pc_write_cond;
   logic             mem_read;
   logic             mem_write;
   logic             mem_to_reg;
   logic             alu_src;
   logic [1:0]       alu_op;
   logic             reg_write;
   logic             illegal;
   logic             timeout;
   logic [CNT_W-1:0] instret;

   modport master (
      input  opcode, imem_ready, dmem_ready,
      output imem_req, ir_write, pc_write, pc_write_cond, mem_read, mem_write,
             mem_to_reg, alu_src, alu_op, reg_write, illegal, timeout, instret
   );

   modport slave (
      output opcode, imem_ready, dmem_ready,
      input  imem_req, ir_write, pc_write, pc_write_cond, mem_read, mem_write,
             mem_to_reg, alu_src, alu_op, reg_write, illegal, timeout, instret
   );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode decode into EXEC-stage control bits plus a legality flag.
module mc_decode
   import mc_control_unit_pkg::*;
#(
   parameter int unsigned OPC_W = 5
) (
   input  logic [OPC_W-1:0] i_op,
   output exec_ctrl_t       o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      unique case (i_op)
         OPC_W'(OpR): begin
            o_ctrl.legal  = 1'b1;
            o_ctrl.alu_op = AluRFunct;
         end
         OPC_W'(OpI): begin
            o_ctrl.legal   = 1'b1;
            o_ctrl.alu_op  = AluIFunct;
            o_ctrl.alu_src = 1'b1;
         end
         OPC_W'(OpLoad): begin
            o_ctrl.legal   = 1'b1;
            o_ctrl.alu_src = 1'b1;
            o_ctrl.is_load = 1'b1;
         end
         OPC_W'(OpStore): begin
            o_ctrl.legal    = 1'b1;
            o_ctrl.alu_src  = 1'b1;
            o_ctrl.is_store = 1'b1;
         end
         OPC_W'(OpBranch): begin
            o_ctrl.legal         = 1'b1;
            o_ctrl.alu_op        = AluCmp;
            o_ctrl.pc_write_cond = 1'b1;
            o_ctrl.is_branch     = 1'b1;
         end
         OPC_W'(OpJal), OPC_W'(OpJalr): begin
            o_ctrl.legal    = 1'b1;
            o_ctrl.alu_src  = 1'b1;
            o_ctrl.pc_write = 1'b1;
         end
         OPC_W'(OpLui), OPC_W'(OpAuipc): begin
            o_ctrl.legal   = 1'b1;
            o_ctrl.alu_src = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with retire counter and
// sticky illegal-opcode / memory-timeout traps.
module mc_control_unit
   import mc_control_unit_pkg::*;
#(
   parameter int unsigned OPC_W   = 5,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input logic               clk,
   input logic               rst_n,
   mc_control_unit_if.master bus
);

   localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t           r_state, w_state_d;
   logic [OPC_W-1:0] r_op, w_op_d, w_dec_op;
   logic [CNT_W-1:0] r_instret;
   logic [WaitW-1:0] r_wait, w_wait_d;
   logic             r_illegal, r_timeout;
   logic             w_retire, w_set_illegal, w_set_timeout, w_timed_out;
   exec_ctrl_t       w_ctrl;

   // DECODE checks the live opcode; every later state uses the latched one.
   assign w_dec_op = (r_state == StDecode) ? bus.opcode : r_op;

   mc_decode #(.OPC_W(OPC_W)) u_decode (
      .i_op   (w_dec_op),
      .o_ctrl (w_ctrl)
   );

   assign w_timed_out = (TIMEOUT > 0) && (r_wait == WaitW'(TIMEOUT));

   always_comb begin
      w_state_d     = r_state;
      w_op_d        = r_op;
      w_wait_d      = '0;
      w_retire      = 1'b0;
      w_set_illegal = 1'b0;
      w_set_timeout = 1'b0;
      unique case (r_state)
         StFetch: begin
            if (w_timed_out) begin
               w_state_d     = StTrap;
               w_set_timeout = 1'b1;
            end else if (bus.imem_ready) begin
               w_state_d = StDecode;
            end else begin
               w_wait_d = (r_wait == '1) ? r_wait : r_wait + 1'b1;
            end
         end
         StDecode: begin
            w_op_d = bus.opcode;
            if (w_ctrl.legal) begin
               w_state_d = StExec;
            end else begin
               w_state_d     = StTrap;
               w_set_illegal = 1'b1;
            end
         end
         StExec: begin
            if (w_ctrl.is_branch) begin
               w_state_d = StFetch;
               w_retire  = 1'b1;
            end else if (w_ctrl.is_load || w_ctrl.is_store) begin
               w_state_d = StMem;
            end else begin
               w_state_d = StWb;
            end
         end
         StMem: begin
            if (w_timed_out) begin
               w_state_d     = StTrap;
               w_set_timeout = 1'b1;
            end else if (bus.dmem_ready) begin
               w_state_d = w_ctrl.is_load ? StWb : StFetch;
               w_retire  = !w_ctrl.is_load;
            end else begin
               w_wait_d = (r_wait == '1) ? r_wait : r_wait + 1'b1;
            end
         end
         StWb: begin
            w_state_d = StFetch;
            w_retire  = 1'b1;
         end
         StTrap:  w_state_d = StTrap;
         default: w_state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= StFetch;
         r_op      <= '0;
         r_instret <= '0;
         r_wait    <= '0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_op      <= w_op_d;
         r_wait    <= w_wait_d;
         r_instret <= r_instret + CNT_W'(w_retire);
         r_illegal <= r_illegal | w_set_illegal;
         r_timeout <= r_timeout | w_set_timeout;
      end
   end

   always_comb begin
      bus.imem_req      = 1'b0;
      bus.ir_write      = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.alu_src       = 1'b0;
      bus.alu_op        = AluAdd;
      bus.reg_write     = 1'b0;
      unique case (r_state)
         StFetch: begin
            bus.imem_req = 1'b1;
            bus.ir_write = bus.imem_ready && !w_timed_out;
            bus.pc_write = bus.imem_ready && !w_timed_out;
         end
         StExec: begin
            bus.alu_op        = w_ctrl.alu_op;
            bus.alu_src       = w_ctrl.alu_src;
            bus.pc_write      = w_ctrl.pc_write;
            bus.pc_write_cond = w_ctrl.pc_write_cond;
         end
         StMem: begin
            bus.mem_read  = w_ctrl.is_load;
            bus.mem_write = w_ctrl.is_store;
         end
         StWb: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = w_ctrl.is_load;
         end
         default: ;
      endcase
   end

   assign bus.illegal = r_illegal;
   assign bus.timeout = r_timeout;
   assign bus.instret = r_instret;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench: a cycle table for the main instruction flows plus hand-written
// reset-in-MEM and timeout sequences on TIMEOUT=16 and TIMEOUT=0 instances.
module tb_mc_control_unit;
   import mc_control_unit_pkg::*;

   // Output vector: {imem_req, ir_write, pc_write, pc_write_cond, mem_read, mem_write,
   //                 mem_to_reg, alu_src, alu_op[1:0], reg_write, illegal, timeout}
   localparam logic [12:0] FW   = 13'h1000;
   localparam logic [12:0] FG   = 13'h1C00;
   localparam logic [12:0] ID   = 13'h0000;
   localparam logic [12:0] EXR  = 13'h0010;
   localparam logic [12:0] EXI  = 13'h0038;
   localparam logic [12:0] EXLS = 13'h0020;
   localparam logic [12:0] EXBR = 13'h0208;
   localparam logic [12:0] EXJ  = 13'h0420;
   localparam logic [12:0] MRD  = 13'h0100;
   localparam logic [12:0] MWR  = 13'h0080;
   localparam logic [12:0] WBR  = 13'h0004;
   localparam logic [12:0] WBL  = 13'h0044;
   localparam logic [12:0] TIL  = 13'h0002;
   localparam logic [12:0] TTO  = 13'h0001;
   localparam logic [4:0]  XOP  = 5'b11111;

   typedef struct {
      logic [4:0]  op;
      logic        ir;
      logic        dr;
      logic [12:0] exp;
      int unsigned ret;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mc_control_unit_if #(.OPC_W(5), .CNT_W(32)) a ();
   mc_control_unit_if #(.OPC_W(5), .CNT_W(32)) b ();

   assign b.opcode     = a.opcode;
   assign b.imem_ready = a.imem_ready;
   assign b.dmem_ready = a.dmem_ready;

   mc_control_unit #(.OPC_W(5), .TIMEOUT(16), .CNT_W(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a)
   );

   mc_control_unit #(.OPC_W(5), .TIMEOUT(0), .CNT_W(32)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   logic [12:0] oa, ob;
   assign oa = {a.imem_req, a.ir_write, a.pc_write, a.pc_write_cond, a.mem_read, a.mem_write,
                a.mem_to_reg, a.alu_src, a.alu_op, a.reg_write, a.illegal, a.timeout};
   assign ob = {b.imem_req, b.ir_write, b.pc_write, b.pc_write_cond, b.mem_read, b.mem_write,
                b.mem_to_reg, b.alu_src, b.alu_op, b.reg_write, b.illegal, b.timeout};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [4:0] op, input logic ir, input logic dr);
      rst_n        = rst;
      a.opcode     = op;
      a.imem_ready = ir;
      a.dmem_ready = dr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic [4:0] op, logic ir, logic dr, logic [12:0] exp,
                               int unsigned ret);
      vec_t v;
      v.op  = op;
      v.ir  = ir;
      v.dr  = dr;
      v.exp = exp;
      v.ret = ret;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      // R, LOAD (3 wait cycles), STORE (after one fetch stall), BRANCH, JAL, I, illegal
      tbl.push_back(mk(XOP, 1, 0, FG, 0));     tbl.push_back(mk(OpR, 0, 0, ID, 0));
      tbl.push_back(mk(XOP, 0, 0, EXR, 0));    tbl.push_back(mk(XOP, 0, 0, WBR, 0));
      tbl.push_back(mk(XOP, 1, 0, FG, 1));     tbl.push_back(mk(OpLoad, 0, 0, ID, 1));
      tbl.push_back(mk(XOP, 0, 0, EXLS, 1));   tbl.push_back(mk(XOP, 0, 0, MRD, 1));
      tbl.push_back(mk(XOP, 0, 0, MRD, 1));    tbl.push_back(mk(XOP, 0, 0, MRD, 1));
      tbl.push_back(mk(XOP, 0, 1, MRD, 1));    tbl.push_back(mk(XOP, 0, 0, WBL, 1));
      tbl.push_back(mk(XOP, 0, 0, FW, 2));     tbl.push_back(mk(XOP, 1, 0, FG, 2));
      tbl.push_back(mk(OpStore, 0, 0, ID, 2)); tbl.push_back(mk(XOP, 0, 0, EXLS, 2));
      tbl.push_back(mk(XOP, 0, 1, MWR, 2));    tbl.push_back(mk(XOP, 1, 0, FG, 3));
      tbl.push_back(mk(OpBranch, 0, 0, ID, 3)); tbl.push_back(mk(XOP, 0, 0, EXBR, 3));
      tbl.push_back(mk(XOP, 1, 0, FG, 4));     tbl.push_back(mk(OpJal, 0, 0, ID, 4));
      tbl.push_back(mk(XOP, 0, 0, EXJ, 4));    tbl.push_back(mk(XOP, 0, 0, WBR, 4));
      tbl.push_back(mk(XOP, 1, 0, FG, 5));     tbl.push_back(mk(OpI, 0, 0, ID, 5));
      tbl.push_back(mk(XOP, 0, 0, EXI, 5));    tbl.push_back(mk(XOP, 0, 0, WBR, 5));
      tbl.push_back(mk(XOP, 1, 0, FG, 6));     tbl.push_back(mk(XOP, 0, 0, ID, 6));
      tbl.push_back(mk(XOP, 1, 0, TIL, 6));    tbl.push_back(mk(XOP, 1, 1, TIL, 6));
      tbl.push_back(mk(OpR, 1, 1, TIL, 6));

      drive(0, XOP, 0, 0);
      tick();
      tick();
      drive(1, XOP, 0, 0);
      chk("reset.outs", 32'(oa), 32'(FW));
      chk("reset.instret", a.instret, 0);

      foreach (tbl[i]) begin
         drive(1, tbl[i].op, tbl[i].ir, tbl[i].dr);
         chk($sformatf("vec%0d.outs", i), 32'(oa), 32'(tbl[i].exp));
         chk($sformatf("vec%0d.instret", i), a.instret, tbl[i].ret);
         chk($sformatf("vec%0d.excl", i),
             32'((32'(a.mem_read) + 32'(a.mem_write) + 32'(a.reg_write)) > 1), 0);
         tick();
      end

      // Reset clears sticky illegal flag and counter
      drive(0, XOP, 1, 1);
      tick();
      drive(1, XOP, 0, 0);
      chk("trap_reset.outs", 32'(oa), 32'(FW));
      chk("trap_reset.instret", a.instret, 0);

      // Retire one R, then reset in the middle of a LOAD's MEM phase
      drive(1, XOP, 1, 0);    tick();
      drive(1, OpR, 0, 0);    tick();
      drive(1, XOP, 0, 0);    tick();
      drive(1, XOP, 0, 0);    tick();
      drive(1, XOP, 1, 0);
      chk("mid.instret", a.instret, 1);
      tick();
      drive(1, OpLoad, 0, 0); tick();
      drive(1, XOP, 0, 0);    tick();
      drive(1, XOP, 0, 0);
      chk("mid.mem", 32'(oa), 32'(MRD));
      tick();
      drive(0, XOP, 0, 1);    tick();
      drive(1, XOP, 0, 0);
      chk("mid_reset.outs", 32'(oa), 32'(FW));
      chk("mid_reset.instret", a.instret, 0);
      chk("mid_reset.outs0", 32'(ob), 32'(FW));

      // LOAD with dmem_ready stuck low: TIMEOUT=16 traps, TIMEOUT=0 keeps waiting
      drive(1, XOP, 1, 0);    tick();
      drive(1, OpLoad, 0, 0); tick();
      drive(1, XOP, 0, 0);    tick();
      for (int i = 1; i <= 17; i++) begin
         drive(1, XOP, 0, 0);
         chk($sformatf("to_mem%0d.a", i), 32'(oa), 32'(MRD));
         chk($sformatf("to_mem%0d.b", i), 32'(ob), 32'(MRD));
         tick();
      end
      for (int i = 18; i <= 60; i++) begin
         drive(1, XOP, 1, 0);
         chk($sformatf("to_trap%0d.a", i), 32'(oa), 32'(TTO));
         chk($sformatf("to_wait%0d.b", i), 32'(ob), 32'(MRD));
         tick();
      end
      drive(1, XOP, 0, 1);
      chk("to_late.b", 32'(ob), 32'(MRD));
      tick();
      drive(1, XOP, 0, 0);
      chk("to_wb.b", 32'(ob), 32'(WBL));
      chk("to_wb.a", 32'(oa), 32'(TTO));
      tick();
      drive(1, XOP, 0, 0);
      chk("to_ret.b", b.instret, 1);
      chk("to_ret.a", a.instret, 0);

      // FETCH timeout: ready arriving on the timeout cycle is ignored
      drive(0, XOP, 0, 0);    tick();
      for (int i = 1; i <= 16; i++) begin
         drive(1, XOP, 0, 0);
         chk($sformatf("fto%0d.a", i), 32'(oa), 32'(FW));
         tick();
      end
      drive(1, XOP, 1, 0);
      chk("fto_ign.a", 32'(oa), 32'(FW));
      chk("fto_go.b", 32'(ob), 32'(FG));
      tick();
      drive(1, XOP, 0, 0);
      chk("fto_trap.a", 32'(oa), 32'(TTO));
      chk("fto_dec.b", 32'(ob), 32'(ID));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
